// File: rtl/scan_pkg.sv
// Shared types and helpers for the scan-order generator.
// State encoding uses plain localparam constants so that older blocks can
// still import it; scan types are a proper enum.
package scan_pkg;

  typedef enum logic [1:0] {
    SCAN_DIAG = 2'd0,
    SCAN_HOR  = 2'd1,
    SCAN_VER  = 2'd2,
    SCAN_RSVD = 2'd3
  } scan_type_e;

  typedef logic [1:0] state_e;

  localparam state_e IDLE = 2'd0;
  localparam state_e LOAD = 2'd1;
  localparam state_e RUN  = 2'd2;
  localparam state_e DONE = 2'd3;

  // A start request is legal when the scan type is defined and both block
  // dimensions lie between 4 and the largest supported size.
  function automatic logic cfg_ok(input logic [2:0]  log2_w,
                                  input logic [2:0]  log2_h,
                                  input logic [1:0]  scan_type,
                                  input int unsigned max_log2_w,
                                  input int unsigned max_log2_h);
    cfg_ok = (scan_type != SCAN_RSVD) &&
             (32'(log2_w) >= 32'd2) && (32'(log2_w) <= max_log2_w) &&
             (32'(log2_h) >= 32'd2) && (32'(log2_h) <= max_log2_h);
  endfunction

endpackage

// File: rtl/scan_step.sv
// Combinational single-step of a coefficient scan: given the current (x, y)
// returns the next position (or the previous one when reverse is set) for
// diagonal, horizontal and vertical orders. Called only on positions that
// have a successor, so the wrap cases at the ends of the block are don't-care.
module scan_step
  import scan_pkg::*;
#(
  parameter int unsigned MAX_LOG2_W = 5,
  parameter int unsigned MAX_LOG2_H = 5,
  localparam int unsigned IDX_W = MAX_LOG2_W + MAX_LOG2_H
) (
  input  logic [MAX_LOG2_W-1:0] x,
  input  logic [MAX_LOG2_H-1:0] y,
  input  logic [2:0]            log2_w,
  input  logic [2:0]            log2_h,
  input  scan_type_e            scan_type,
  input  logic                  reverse,
  output logic [MAX_LOG2_W-1:0] next_x,
  output logic [MAX_LOG2_H-1:0] next_y
);

  localparam logic [IDX_W-1:0] ONE = IDX_W'(1);

  logic [IDX_W-1:0] xe;
  logic [IDX_W-1:0] ye;
  logic [IDX_W-1:0] w_m1;
  logic [IDX_W-1:0] h_m1;
  logic [IDX_W-1:0] d;
  logic [IDX_W-1:0] nx;
  logic [IDX_W-1:0] ny;

  // Work in index-wide arithmetic so the anti-diagonal sum x+y never wraps.
  always_comb begin
    xe   = IDX_W'(x);
    ye   = IDX_W'(y);
    w_m1 = (ONE << log2_w) - ONE;
    h_m1 = (ONE << log2_h) - ONE;
    d    = '0;
    nx   = xe;
    ny   = ye;
    case (scan_type)
      SCAN_DIAG: begin
        if (!reverse) begin
          if ((ye == '0) || (xe == w_m1)) begin
            d  = xe + ye + ONE;
            ny = (d < h_m1) ? d : h_m1;
            nx = d - ny;
          end else begin
            nx = xe + ONE;
            ny = ye - ONE;
          end
        end else begin
          if ((xe == '0) || (ye == h_m1)) begin
            d  = xe + ye - ONE;
            nx = (d < w_m1) ? d : w_m1;
            ny = d - nx;
          end else begin
            nx = xe - ONE;
            ny = ye + ONE;
          end
        end
      end
      SCAN_HOR: begin
        if (!reverse) begin
          if (xe == w_m1) begin
            nx = '0;
            ny = ye + ONE;
          end else begin
            nx = xe + ONE;
          end
        end else begin
          if (xe == '0) begin
            nx = w_m1;
            ny = ye - ONE;
          end else begin
            nx = xe - ONE;
          end
        end
      end
      SCAN_VER: begin
        if (!reverse) begin
          if (ye == h_m1) begin
            ny = '0;
            nx = xe + ONE;
          end else begin
            ny = ye + ONE;
          end
        end else begin
          if (ye == '0) begin
            ny = h_m1;
            nx = xe - ONE;
          end else begin
            ny = ye - ONE;
          end
        end
      end
      default: begin
        nx = xe;
        ny = ye;
      end
    endcase
    next_x = MAX_LOG2_W'(nx);
    next_y = MAX_LOG2_H'(ny);
  end

endmodule

// File: rtl/scan_pattern_gen.sv
// Scan-order generator for RDOQ coefficient processing. Walks a transform
// block in diagonal, horizontal or vertical order, forward or reverse, and
// streams one (x, y, raster, index) tuple per cycle over valid/ready.
// Optional feature macro SCAN_LAST_POS_EN: adds the last_pos port and lets a
// reverse scan start at an arbitrary scan index, found by a forward seek in
// LOAD.
module scan_pattern_gen
  import scan_pkg::*;
#(
  parameter int unsigned MAX_LOG2_W = 5,
  parameter int unsigned MAX_LOG2_H = 5,
  localparam int unsigned IDX_W = MAX_LOG2_W + MAX_LOG2_H
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            log2_w,
  input  logic [2:0]            log2_h,
  input  logic [1:0]            scan_type,
  input  logic                  reverse,
`ifdef SCAN_LAST_POS_EN
  input  logic [IDX_W-1:0]      last_pos,
`endif
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [MAX_LOG2_W-1:0] out_x,
  output logic [MAX_LOG2_H-1:0] out_y,
  output logic [IDX_W-1:0]      out_raster,
  output logic [IDX_W-1:0]      out_idx,
  output logic                  out_last,
  output logic                  done,
  output logic                  cfg_err
);

  localparam logic [IDX_W-1:0] ONE = IDX_W'(1);

  state_e                state_q,     state_d;
  logic [2:0]            log2_w_q,    log2_w_d;
  logic [2:0]            log2_h_q,    log2_h_d;
  scan_type_e            scan_type_q, scan_type_d;
  logic                  reverse_q,   reverse_d;
  logic [MAX_LOG2_W-1:0] x_q,         x_d;
  logic [MAX_LOG2_H-1:0] y_q,         y_d;
  logic [IDX_W-1:0]      idx_q,       idx_d;
  logic                  cfg_err_q,   cfg_err_d;
`ifdef SCAN_LAST_POS_EN
  logic [IDX_W-1:0]      target_q,    target_d;
  logic [IDX_W-1:0]      target_clamped;
`else
  logic [IDX_W-1:0]      w_m1;
  logic [IDX_W-1:0]      h_m1;
`endif

  logic [IDX_W-1:0]      n_m1;
  logic                  handshake;
  logic                  step_reverse;
  logic [MAX_LOG2_W-1:0] step_x;
  logic [MAX_LOG2_H-1:0] step_y;

  // The seek in LOAD always walks forward; only RUN honours the direction.
  assign step_reverse = reverse_q && (state_q == RUN);

  scan_step #(
    .MAX_LOG2_W (MAX_LOG2_W),
    .MAX_LOG2_H (MAX_LOG2_H)
  ) u_step (
    .x         (x_q),
    .y         (y_q),
    .log2_w    (log2_w_q),
    .log2_h    (log2_h_q),
    .scan_type (scan_type_q),
    .reverse   (step_reverse),
    .next_x    (step_x),
    .next_y    (step_y)
  );

  // N-1 wraps cleanly to all-ones when the block fills the whole index range.
  assign n_m1 = (ONE << ({1'b0, log2_w_q} + {1'b0, log2_h_q})) - ONE;
`ifdef SCAN_LAST_POS_EN
  assign target_clamped = (target_q > n_m1) ? n_m1 : target_q;
`else
  assign w_m1 = (ONE << log2_w_q) - ONE;
  assign h_m1 = (ONE << log2_h_q) - ONE;
`endif

  assign busy       = (state_q == LOAD) || (state_q == RUN);
  assign out_valid  = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign cfg_err    = cfg_err_q;
  assign out_x      = x_q;
  assign out_y      = y_q;
  assign out_raster = (IDX_W'(y_q) << log2_w_q) | IDX_W'(x_q);
  assign out_idx    = idx_q;
  assign out_last   = (state_q == RUN) && (reverse_q ? (idx_q == '0) : (idx_q == n_m1));
  assign handshake  = out_valid && out_ready;

  // Next-state logic: config capture, first-tuple setup, and stepping on
  // each accepted tuple.
  always_comb begin
    state_d     = state_q;
    log2_w_d    = log2_w_q;
    log2_h_d    = log2_h_q;
    scan_type_d = scan_type_q;
    reverse_d   = reverse_q;
    x_d         = x_q;
    y_d         = y_q;
    idx_d       = idx_q;
    cfg_err_d   = 1'b0;
`ifdef SCAN_LAST_POS_EN
    target_d    = target_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_ok(log2_w, log2_h, scan_type, MAX_LOG2_W, MAX_LOG2_H)) begin
            state_d     = LOAD;
            log2_w_d    = log2_w;
            log2_h_d    = log2_h;
            scan_type_d = scan_type_e'(scan_type);
            reverse_d   = reverse;
            x_d         = '0;
            y_d         = '0;
            idx_d       = '0;
`ifdef SCAN_LAST_POS_EN
            target_d    = last_pos;
`endif
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      LOAD: begin
`ifdef SCAN_LAST_POS_EN
        if (reverse_q) begin
          if (idx_q == target_clamped) begin
            state_d = RUN;
          end else begin
            x_d   = step_x;
            y_d   = step_y;
            idx_d = idx_q + ONE;
          end
        end else begin
          state_d = RUN;
        end
`else
        if (reverse_q) begin
          x_d   = MAX_LOG2_W'(w_m1);
          y_d   = MAX_LOG2_H'(h_m1);
          idx_d = n_m1;
        end
        state_d = RUN;
`endif
      end
      RUN: begin
        if (handshake) begin
          if (out_last) begin
            state_d = DONE;
          end else begin
            x_d   = step_x;
            y_d   = step_y;
            idx_d = reverse_q ? (idx_q - ONE) : (idx_q + ONE);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any scan in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      log2_w_q    <= '0;
      log2_h_q    <= '0;
      scan_type_q <= SCAN_DIAG;
      reverse_q   <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      idx_q       <= '0;
      cfg_err_q   <= 1'b0;
`ifdef SCAN_LAST_POS_EN
      target_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      log2_w_q    <= log2_w_d;
      log2_h_q    <= log2_h_d;
      scan_type_q <= scan_type_d;
      reverse_q   <= reverse_d;
      x_q         <= x_d;
      y_q         <= y_d;
      idx_q       <= idx_d;
      cfg_err_q   <= cfg_err_d;
`ifdef SCAN_LAST_POS_EN
      target_q    <= target_d;
`endif
    end
  end

endmodule
